// File: rtl/vdc_vram_pkg.sv
// Shared types and constants for the VDC VRAM arbiter slice.
package vdc_vram_pkg;

  localparam int unsigned VRAM_WORDS = 32768;
  localparam int unsigned VRAM_AW    = $clog2(VRAM_WORDS);
  localparam int unsigned MAW        = 16;
  localparam int unsigned DW         = 16;

  typedef enum logic [1:0] {
    REQ_DISP = 2'd0,
    REQ_CPU  = 2'd1,
    REQ_DMA  = 2'd2
  } vram_req_t;

  typedef struct packed {
    logic [MAW-1:0] addr;
    logic           we;
    logic [DW-1:0]  wdata;
  } vram_cmd_t;

endpackage

// File: rtl/vram_rr_pick.sv
// Two-way round-robin picker; last_b_q remembers whether side b won most recently.
module vram_rr_pick (
  input  logic clock,
  input  logic reset_N,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic upd_a_i,
  input  logic upd_b_i,
  output logic pick_a_c_o,
  output logic pick_b_c_o
);

  logic last_b_q;

  // On a tie the side that did not win last time goes first.
  assign pick_a_c_o = req_a_i && (!req_b_i || last_b_q);
  assign pick_b_c_o = req_b_i && (!req_a_i || !last_b_q);

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      last_b_q <= 1'b1;
    end else if (upd_a_i) begin
      last_b_q <= 1'b0;
    end else if (upd_b_i) begin
      last_b_q <= 1'b1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: display > {cpu, dma round-robin}, with cpu starvation override.
// Optional build macro VRAM_WRITE_PROTECT_EN blocks writes above 32K words and pulses err.
module vram_arbiter
  import vdc_vram_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned AW       = 16
) (
  input  logic          clock,
  input  logic          reset_N,
  input  logic          disp_req,
  input  logic          cpu_req,
  input  logic          dma_req,
  input  logic          disp_we,
  input  logic          cpu_we,
  input  logic          dma_we,
  input  logic [AW-1:0] disp_addr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [AW-1:0] dma_addr,
  input  logic [15:0]   cpu_wdata,
  input  logic [15:0]   dma_wdata,
  output logic          disp_gnt,
  output logic          cpu_gnt,
  output logic          dma_gnt,
  output logic          rvalid,
  output logic [1:0]    rtag,
  output logic [15:0]   rdata,
  output logic [15:0]   MA,
  output logic          re,
  output logic          we,
  output logic [15:0]   MD_in,
  input  logic [15:0]   MD_out,
  output logic          err
);

  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);

`ifdef VRAM_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           starve_c;
  logic           pick_cpu_c, pick_dma_c;
  logic           gnt_any_c;
  logic           blocked_c;
  vram_cmd_t      cmd_c;
  vram_req_t      tag_c;

  logic [15:0]    ma_q, md_in_q;
  logic           re_q, we_q, err_q;
  vram_req_t      tag1_q, rtag_q;
  logic           rvalid_q;

  vram_rr_pick u_rr_pick (
    .clock      (clock),
    .reset_N    (reset_N),
    .req_a_i    (cpu_req),
    .req_b_i    (dma_req),
    .upd_a_i    (cpu_gnt),
    .upd_b_i    (dma_gnt),
    .pick_a_c_o (pick_cpu_c),
    .pick_b_c_o (pick_dma_c)
  );

  assign starve_c = cpu_req && (wait_cnt_q == WCW'(MAX_WAIT));

  // Grant selection and winner command mux.
  always_comb begin
    disp_gnt = 1'b0;
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    cmd_c    = '0;
    tag_c    = REQ_DISP;
    if (starve_c) begin
      cpu_gnt = 1'b1;
    end else if (disp_req) begin
      disp_gnt = 1'b1;
    end else begin
      cpu_gnt = pick_cpu_c;
      dma_gnt = pick_dma_c;
    end
    if (disp_gnt) begin
      cmd_c.addr = MAW'(disp_addr);
      cmd_c.we   = disp_we;
      tag_c      = REQ_DISP;
    end else if (cpu_gnt) begin
      cmd_c.addr  = MAW'(cpu_addr);
      cmd_c.we    = cpu_we;
      cmd_c.wdata = cpu_wdata;
      tag_c       = REQ_CPU;
    end else if (dma_gnt) begin
      cmd_c.addr  = MAW'(dma_addr);
      cmd_c.we    = dma_we;
      cmd_c.wdata = dma_wdata;
      tag_c       = REQ_DMA;
    end
  end

  assign gnt_any_c  = disp_gnt || cpu_gnt || dma_gnt;
  assign blocked_c  = WP_EN && gnt_any_c && cmd_c.we && cmd_c.addr[VRAM_AW];
  assign wait_cnt_d = (cpu_req && !cpu_gnt) ? wait_cnt_q + WCW'(1) : '0;

  // T1 command register and T2 read-return tag pipeline.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      wait_cnt_q <= '0;
      ma_q       <= '0;
      md_in_q    <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      tag1_q     <= REQ_DISP;
      rvalid_q   <= 1'b0;
      rtag_q     <= REQ_DISP;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (gnt_any_c) begin
        ma_q    <= cmd_c.addr;
        md_in_q <= cmd_c.wdata;
      end
      re_q     <= gnt_any_c && !cmd_c.we;
      we_q     <= gnt_any_c && cmd_c.we && !blocked_c;
      err_q    <= blocked_c;
      tag1_q   <= tag_c;
      rvalid_q <= re_q;
      rtag_q   <= tag1_q;
    end
  end

  assign MA     = ma_q;
  assign MD_in  = md_in_q;
  assign re     = re_q;
  assign we     = we_q;
  assign err    = err_q;
  assign rvalid = rvalid_q;
  assign rtag   = rtag_q;
  assign rdata  = MD_out;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: grant vectors, directed corner cases, random traffic vs model.
module tb_vram_arbiter;
  import vdc_vram_pkg::*;

  localparam int unsigned MAX_WAIT = 8;
`ifdef VRAM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_N = 1'b0;
  logic        disp_req = 0, cpu_req = 0, dma_req = 0;
  logic        disp_we = 0, cpu_we = 0, dma_we = 0;
  logic [15:0] disp_addr = 0, cpu_addr = 0, dma_addr = 0;
  logic [15:0] cpu_wdata = 0, dma_wdata = 0;
  logic        disp_gnt, cpu_gnt, dma_gnt;
  logic        rvalid;
  logic [1:0]  rtag;
  logic [15:0] rdata, MA, MD_in, MD_out;
  logic        re, we, err;

  always #5 clock = ~clock;

  vram_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(16)) dut (
    .clock(clock), .reset_N(reset_N),
    .disp_req(disp_req), .cpu_req(cpu_req), .dma_req(dma_req),
    .disp_we(disp_we), .cpu_we(cpu_we), .dma_we(dma_we),
    .disp_addr(disp_addr), .cpu_addr(cpu_addr), .dma_addr(dma_addr),
    .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
    .disp_gnt(disp_gnt), .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt),
    .rvalid(rvalid), .rtag(rtag), .rdata(rdata),
    .MA(MA), .re(re), .we(we), .MD_in(MD_in), .MD_out(MD_out), .err(err)
  );

  // VRAM model: write commits and read data registers on the clock after the strobe.
  logic [15:0] vram    [VRAM_WORDS];
  logic [15:0] ref_mem [VRAM_WORDS];
  always @(posedge clock) begin
    if (we) vram[MA[14:0]] <= MD_in;
    if (re) MD_out <= vram[MA[14:0]];
  end

  typedef struct {
    bit          v;
    bit          rd;
    bit          wr;
    bit          er;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          tag;
    logic [15:0] rdat;
  } exp_t;

  typedef struct {
    bit         d, c, m;
    logic [2:0] exp_gnt;
    bit         exp_re;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   m_wait;
  bit   m_last_cpu;
  exp_t p1, p2;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_wait     = 0;
    m_last_cpu = 1'b0;
    p1         = '{default: 0};
    p2         = '{default: 0};
  endfunction

  // 0 disp, 1 cpu, 2 dma, 3 none
  function automatic int model_winner();
    if (cpu_req && m_wait == MAX_WAIT) return 1;
    if (disp_req) return 0;
    if (cpu_req && dma_req) return m_last_cpu ? 2 : 1;
    if (cpu_req) return 1;
    if (dma_req) return 2;
    return 3;
  endfunction

  // One clock: check grants, advance the model, check T1 and T2 outputs at the next negedge.
  task automatic tick(output int w);
    exp_t        n;
    logic [15:0] a, wd;
    bit          iw, pr;
    logic [2:0]  eg;
    #1;
    w  = model_winner();
    eg = (w == 3) ? 3'b000 : 3'(1 << w);
    chk("gnt", 32'({dma_gnt, cpu_gnt, disp_gnt}), 32'(eg));
    n = '{default: 0};
    if (w != 3) begin
      a  = (w == 0) ? disp_addr : (w == 1) ? cpu_addr : dma_addr;
      iw = (w == 0) ? disp_we : (w == 1) ? cpu_we : dma_we;
      wd = (w == 0) ? 16'h0 : (w == 1) ? cpu_wdata : dma_wdata;
      pr = PROT && iw && (a >= 16'(VRAM_WORDS));
      n.v = 1; n.addr = a; n.wdata = wd; n.tag = w;
      n.rd = !iw; n.wr = iw && !pr; n.er = pr;
      if (!iw) n.rdat = ref_mem[a[14:0]];
      else if (!pr) ref_mem[a[14:0]] = wd;
    end
    if (w == 1) m_last_cpu = 1'b1;
    else if (w == 2) m_last_cpu = 1'b0;
    m_wait = (cpu_req && w != 1) ? m_wait + 1 : 0;
    p2 = p1;
    p1 = n;
    @(negedge clock);
    chk("t1_re", 32'(re), 32'(p1.rd));
    chk("t1_we", 32'(we), 32'(p1.wr));
    chk("t1_err", 32'(err), 32'(p1.er));
    if (p1.v) chk("t1_ma", 32'(MA), 32'(p1.addr));
    if (p1.wr) chk("t1_md_in", 32'(MD_in), 32'(p1.wdata));
    chk("t2_rvalid", 32'(rvalid), 32'(p2.v && p2.rd));
    if (p2.v && p2.rd) begin
      chk("t2_rtag", 32'(rtag), 32'(p2.tag));
      chk("t2_rdata", 32'(rdata), 32'(p2.rdat));
    end
  endtask

  task automatic idle_inputs();
    disp_req = 0; cpu_req = 0; dma_req = 0;
    disp_we = 0; cpu_we = 0; dma_we = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_N = 1'b0;
    @(negedge clock);
    model_reset();
    chk("rst_outs", 32'({re, we, err, rvalid, rtag}), 32'h0);
    chk("rst_ma", 32'(MA), 32'h0);
    chk("rst_md_in", 32'(MD_in), 32'h0);
    reset_N = 1'b1;
    @(negedge clock);
  endtask

  vec_t vecs[7];
  int   w;

  initial begin
    for (int i = 0; i < int'(VRAM_WORDS); i++) begin
      vram[i]    = 16'(i * 7) ^ 16'h3C5A;
      ref_mem[i] = 16'(i * 7) ^ 16'h3C5A;
    end
    vram[16'h0123]    = 16'hBEEF;
    ref_mem[16'h0123] = 16'hBEEF;

    // Grant vectors, each from a fresh reset (rr_last = dma, wait = 0).
    vecs[0] = '{d: 1, c: 1, m: 1, exp_gnt: 3'b001, exp_re: 1};
    vecs[1] = '{d: 0, c: 1, m: 1, exp_gnt: 3'b010, exp_re: 1};
    vecs[2] = '{d: 0, c: 0, m: 1, exp_gnt: 3'b100, exp_re: 1};
    vecs[3] = '{d: 0, c: 1, m: 0, exp_gnt: 3'b010, exp_re: 1};
    vecs[4] = '{d: 0, c: 0, m: 0, exp_gnt: 3'b000, exp_re: 0};
    vecs[5] = '{d: 1, c: 0, m: 1, exp_gnt: 3'b001, exp_re: 1};
    vecs[6] = '{d: 1, c: 1, m: 0, exp_gnt: 3'b001, exp_re: 1};
    disp_addr = 16'h0010; cpu_addr = 16'h0020; dma_addr = 16'h0030;
    for (int i = 0; i < 7; i++) begin
      do_reset();
      disp_req = vecs[i].d; cpu_req = vecs[i].c; dma_req = vecs[i].m;
      #1;
      chk("vec_gnt", 32'({dma_gnt, cpu_gnt, disp_gnt}), 32'(vecs[i].exp_gnt));
      tick(w);
      chk("vec_re", 32'(re), 32'(vecs[i].exp_re));
      idle_inputs();
    end

    // Single uncontended cpu read.
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0123;
    tick(w);
    cpu_req = 0;
    chk("rd_ma", 32'(MA), 32'h0123);
    chk("rd_re", 32'(re), 32'h1);
    tick(w);
    chk("rd_t2", 32'({rvalid, rtag, rdata}), {13'h0, 1'b1, 2'd1, 16'hBEEF});

    // cpu and dma contend: strict alternation starting with cpu.
    do_reset();
    cpu_req = 1; dma_req = 1; cpu_addr = 16'h0005; dma_addr = 16'h0006;
    for (int i = 0; i < 6; i++) begin
      tick(w);
      chk("alt_winner", 32'(w), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    idle_inputs();
    tick(w);
    tick(w);

    // Starvation override: cpu wins on the 9th cycle of continuous display.
    do_reset();
    disp_req = 1; disp_addr = 16'h0100; cpu_req = 1; cpu_addr = 16'h0200;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("starve_gnt", 32'({cpu_gnt, disp_gnt}), (i == 8) ? 32'b10 : 32'b01);
      tick(w);
      if (w == 1) cpu_req = 0;
    end
    cpu_req = 1;
    for (int i = 0; i < 9; i++) begin
      tick(w);
      if (w == 1) cpu_req = 0;
    end
    chk("starve_again", 32'(cpu_req), 32'h0);
    idle_inputs();
    tick(w);
    tick(w);

    // Read-after-write: cpu write followed by dma read of the same word.
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 16'h5A5A;
    tick(w);
    cpu_req = 0; cpu_we = 0;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0040;
    tick(w);
    dma_req = 0;
    tick(w);
    chk("raw_t2", 32'({rvalid, rtag, rdata}), {13'h0, 1'b1, 2'd2, 16'h5A5A});

    // Reset asserted while a read is in flight.
    do_reset();
    cpu_req = 1; cpu_addr = 16'h0123;
    tick(w);
    cpu_req = 0;
    reset_N = 1'b0;
    #1;
    chk("midrst_outs", 32'({re, we, err, rvalid, rtag}), 32'h0);
    chk("midrst_ma", 32'(MA), 32'h0);
    @(negedge clock);
    model_reset();
    reset_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(w);
      chk("midrst_no_rvalid", 32'(rvalid), 32'h0);
    end

    // Write above 32K words.
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h8001; cpu_wdata = 16'h1111;
    #1;
    chk("wp_gnt", 32'(cpu_gnt), 32'h1);
    tick(w);
    cpu_req = 0; cpu_we = 0;
    chk("wp_we_err", 32'({we, err}), PROT ? 32'b01 : 32'b10);
    tick(w);
    chk("wp_err_pulse", 32'(err), 32'h0);

    // Random traffic against the model, three display-load levels.
    for (int ph = 0; ph < 3; ph++) begin
      int dpct;
      dpct = (ph == 0) ? 10 : (ph == 1) ? 50 : 95;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        if (!disp_req && $urandom_range(0, 99) < dpct) begin
          disp_req = 1;
          disp_addr = $urandom_range(0, 1) ? 16'($urandom_range(0, 31)) : 16'($urandom);
        end
        if (!cpu_req && $urandom_range(0, 99) < 40) begin
          cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = $urandom_range(0, 1) ? 16'($urandom_range(0, 31)) : 16'($urandom);
          cpu_wdata = 16'($urandom);
        end
        if (!dma_req && $urandom_range(0, 99) < 40) begin
          dma_req = 1; dma_we = 1'($urandom_range(0, 1));
          dma_addr = $urandom_range(0, 1) ? 16'($urandom_range(0, 31)) : 16'($urandom);
          dma_wdata = 16'($urandom);
        end
        tick(w);
        if (w == 0) disp_req = 0;
        if (w == 1) cpu_req = 0;
        if (w == 2) dma_req = 0;
      end
    end
    idle_inputs();
    tick(w);
    tick(w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-ported VDC VRAM between three requesters: display fetch (BG/sprite), CPU port (MAWR/MARR accesses) and VRAM-to-VRAM/SATB DMA.
- Grants at most one access per clock and registers the winning command onto the VRAM port.
- Routes the registered read data back to the originating requester with a tag.
- Sits between the VDC register/fetch logic and the VRAM model.

Parameters:
- MAX_WAIT, 8: cycles a CPU request may be denied by display before it preempts display for one slot.
- AW, 16: VRAM word address width on the requester side.

Ports:
- clock  in  1  system clock
- reset_N  in  1  asynchronous active-low reset
- disp_req, cpu_req, dma_req  in  1 each  access request, level; held until granted
- disp_we, cpu_we, dma_we  in  1 each  1 = write, 0 = read
- disp_addr, cpu_addr, dma_addr  in  AW each  word address
- cpu_wdata, dma_wdata  in  16 each  write data (display never writes)
- disp_gnt, cpu_gnt, dma_gnt  out  1 each  combinational grant, same cycle as req
- rvalid  out  1  read data valid
- rtag  out  2  owner of rdata: 0 = disp, 1 = cpu, 2 = dma
- rdata  out  16  read data (direct from VRAM MD_out)
- MA  out  16  VRAM address, registered
- re, we  out  1 each  VRAM read/write strobes, registered
- MD_in  out  16  VRAM write data, registered
- MD_out  in  16  VRAM read data; the VRAM registers it one clock after re
- err  out  1  protection violation pulse (feature-dependent; tied 0 when the feature is compiled out)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. Reset clears all outputs to 0, wait_cnt to 0 and rr_last to dma (so cpu wins the first tie).
- Grant priority:
  - disp > {cpu, dma}.
  - cpu vs dma is round-robin via rr_last, updated only when one of them is granted.
- Starvation override:
  - wait_cnt increments each cycle cpu_req=1 and cpu_gnt=0.
  - When wait_cnt == MAX_WAIT, cpu is granted over disp that cycle.
  - wait_cnt clears on cpu_gnt or when cpu_req=0.
- Grant rules:
  - Exactly one gnt is high when any req is high; all gnt are low when no req is high.
  - A gnt is only asserted with its req.
  - A requester drops or changes req/addr only after its gnt.
- Pipeline:
  - T0: gnt.
  - T1: MA/we/re/MD_in hold the T0 winner; re = ~we; both low if nothing was granted.
  - T2: VRAM returns data; rvalid=1 and rtag = T0 winner, for reads only.
- Throughput and ordering:
  - Back-to-back grants are allowed every cycle; a full rate of one access per clock is sustained.
  - Tags pipeline through two flops. No reordering.
- Read-after-write: a T0 write followed by a T1 read to the same address returns the new data, because the VRAM write commits at T1 before the T2 read capture. No forwarding is required.
- Reset mid-operation: in-flight reads are dropped. No rvalid is produced after reset deasserts for accesses granted before reset.
- Addresses reach the VRAM port unmodified; the VRAM decodes the low 15 bits.

Optional Feature:
- VRAM_WRITE_PROTECT_EN:
  - Defined: a granted write with addr[15]=1 (beyond 32K words) still gets gnt but drives we=0, re=0 at T1, and err pulses high for one cycle at T1.
  - Undefined: writes pass unmodified and err is constant 0.

Decomposition:
- Package vdc_vram_pkg holds:
  - typedef enum logic [1:0] {REQ_DISP, REQ_CPU, REQ_DMA} vram_req_t
  - localparam VRAM_WORDS = 32768
  - typedef struct for the command {addr, we, wdata}
- Sub-module vram_rr_pick: 2-way round-robin picker with rr_last state. Used for cpu/dma.

Test Plan:
- Single cpu read of 0x0123 (VRAM preloaded 0xBEEF), no contention -> cpu_gnt at T0, MA=0x0123 re=1 at T1, rvalid=1 rtag=1 rdata=0xBEEF at T2.
- cpu_req and dma_req held 6 cycles, disp idle -> grants alternate cpu, dma, cpu, dma, cpu, dma.
- disp_req held continuously, cpu read pending -> cpu denied 8 cycles, granted on the 9th cycle, disp granted again the next cycle; wait_cnt returns to 0.
- cpu write 0x5A5A to 0x0040 then dma read of 0x0040 on the next cycle -> dma rvalid with rdata=0x5A5A, rtag=2.
- Reset asserted with a read granted one cycle earlier -> all outputs 0 immediately; no rvalid after release.
- With VRAM_WRITE_PROTECT_EN: cpu write to 0x8001 -> cpu_gnt=1, we=0 at T1, err=1 for one cycle. Without the macro: we=1, err=0.
